// File: rtl/dbg_abstract_sequencer.sv
// -----------------------------------------------------------------------------
// dbg_abstract_sequencer
//   Runs RISC-V debug "Access Register" abstract commands. A command word is
//   latched from the DM, decoded and validated for one cycle, and then drives a
//   single transaction onto either the GPR port or the CSR port. Read data goes
//   back to data0, regno can be post-incremented, and busy/cmderr are reported.
//
// Ports
//   iClk, iRst_n            clock, async active-low reset
//   iClear                  sync clear (dmactive=0), overrides everything
//   iHalted                 hart halted
//   iCmdValid/iCmd          command register write pulse + word
//   iCmdErrW1c              write-1-to-clear mask for cmderr
//   iData0                  data0 contents (write source)
//   oBusy/oCmdErr           abstractcs.busy / abstractcs.cmderr
//   oData0We/oData0         data0 load pulse + read result
//   oRegnoWe/oRegno         command.regno post-increment pulse + value
//   oRf*/iRf*               GPR access port (req/we/addr/wdata, ack/rdata)
//   oCsr*/iCsr*             CSR access port (req/we/addr/wdata, ack/rdata)
// -----------------------------------------------------------------------------
module dbg_abstract_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iClear,
  input  logic        iHalted,
  input  logic        iCmdValid,
  input  logic [31:0] iCmd,
  input  logic [2:0]  iCmdErrW1c,
  input  logic [31:0] iData0,
  output logic        oBusy,
  output logic [2:0]  oCmdErr,
  output logic        oData0We,
  output logic [31:0] oData0,
  output logic        oRegnoWe,
  output logic [15:0] oRegno,
  output logic        oRfReq,
  output logic        oRfWe,
  output logic [4:0]  oRfAddr,
  output logic [31:0] oRfWdata,
  input  logic        iRfAck,
  input  logic [31:0] iRfRdata,
  output logic        oCsrReq,
  output logic        oCsrWe,
  output logic [11:0] oCsrAddr,
  output logic [31:0] oCsrWdata,
  input  logic        iCsrAck,
  input  logic [31:0] iCsrRdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_REQ, S_WAIT, S_DONE
  } state_t;

  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXCEPT = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;
  localparam logic [2:0] ERR_BUS    = 3'd5;
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cmd;
  logic [2:0]  r_cmderr;
  logic        r_req;
  logic        r_csr_tgt;
  logic        r_err_this;   // the running command itself has failed
  logic [7:0]  r_cnt;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  // command fields
  logic [7:0]  w_cmdtype;
  logic [2:0]  w_aarsize;
  logic        w_postinc, w_postexec, w_transfer, w_write;
  logic [15:0] w_regno;
  logic        w_unused;

  assign w_cmdtype  = r_cmd[31:24];
  assign w_aarsize  = r_cmd[22:20];
  assign w_postinc  = r_cmd[19];
  assign w_postexec = r_cmd[18];
  assign w_transfer = r_cmd[17];
  assign w_write    = r_cmd[16];
  assign w_regno    = r_cmd[15:0];
  assign w_unused   = r_cmd[23];

  logic        w_accept, w_ack;
  logic        w_own_err, w_err_vld;
  logic [2:0]  w_err_code;
  logic        w_go_req, w_go_csr, w_x0, w_ack_hit, w_timeout;

  // only a command arriving while idle and error-free is taken
  assign w_accept = iCmdValid && (r_state == S_IDLE) && (r_cmderr == 3'd0);
  assign w_ack    = r_csr_tgt ? iCsrAck : iRfAck;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_own_err   = 1'b0;
    w_err_vld   = 1'b0;
    w_err_code  = 3'd0;
    w_go_req    = 1'b0;
    w_go_csr    = 1'b0;
    w_x0        = 1'b0;
    w_ack_hit   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_state_nxt = S_DONE;
        if (w_cmdtype != 8'd0 || w_postexec) begin
          w_own_err = 1'b1; w_err_code = ERR_NOTSUP;
        end else if (!w_transfer) begin
          // nothing to move; aarsize deliberately not checked
        end else if (w_aarsize != 3'd2) begin
          w_own_err = 1'b1; w_err_code = ERR_NOTSUP;
        end else if (!iHalted) begin
          w_own_err = 1'b1; w_err_code = ERR_HALT;
        end else if (w_regno <= 16'h0FFF) begin
          w_go_req = 1'b1; w_go_csr = 1'b1; w_state_nxt = S_REQ;
        end else if (w_regno >= 16'h1001 && w_regno <= 16'h101F) begin
          w_go_req = 1'b1; w_state_nxt = S_REQ;
        end else if (w_regno == 16'h1000) begin
          w_x0 = 1'b1;  // x0: hardwired zero, no bus cycle
        end else begin
          w_own_err = 1'b1; w_err_code = ERR_EXCEPT;
        end
      end
      // first cycle of Req: the ack is not looked at yet
      S_REQ: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_ack) begin
          w_ack_hit = 1'b1; w_state_nxt = S_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1; w_own_err = 1'b1; w_err_code = ERR_BUS;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_err_vld = w_own_err;
    // a command written while busy is dropped; its error only lands if the
    // running command did not produce one in the same cycle
    if (iCmdValid && r_state != S_IDLE && !w_own_err) begin
      w_err_vld = 1'b1; w_err_code = ERR_BUSY;
    end
    if (iClear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cmd      <= '0;
      r_cmderr   <= '0;
      r_req      <= 1'b0;
      r_csr_tgt  <= 1'b0;
      r_err_this <= 1'b0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else if (iClear) begin
      r_cmd      <= '0;
      r_cmderr   <= '0;
      r_req      <= 1'b0;
      r_csr_tgt  <= 1'b0;
      r_err_this <= 1'b0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_cmd      <= iCmd;
        r_err_this <= 1'b0;
      end
      if (w_own_err) r_err_this <= 1'b1;
      // first error sticks; a set beats a same-cycle W1C
      if (w_err_vld && r_cmderr == 3'd0) r_cmderr <= w_err_code;
      else                               r_cmderr <= r_cmderr & ~iCmdErrW1c;
      if (w_go_req) begin
        r_req     <= 1'b1;
        r_csr_tgt <= w_go_csr;
        r_cnt     <= '0;
        r_wdata   <= iData0;  // held stable for the whole request
      end
      if (r_state == S_WAIT) begin
        if (w_ack_hit || w_timeout) r_req <= 1'b0;
        else                        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack_hit && !w_write) r_rdata <= r_csr_tgt ? iCsrRdata : iRfRdata;
      if (w_x0) r_rdata <= '0;
    end
  end

  logic w_done_ok;
  assign w_done_ok = (r_state == S_DONE) && !r_err_this;

  assign oBusy     = (r_state != S_IDLE);
  assign oCmdErr   = r_cmderr;
  assign oData0We  = w_done_ok && w_transfer && !w_write;
  assign oData0    = r_rdata;
  assign oRegnoWe  = w_done_ok && w_postinc;
  assign oRegno    = oRegnoWe ? (w_regno + 16'd1) : 16'd0;

  assign oRfReq    = r_req && !r_csr_tgt;
  assign oRfWe     = oRfReq && w_write;
  assign oRfAddr   = oRfReq ? w_regno[4:0] : 5'd0;
  assign oRfWdata  = oRfReq ? r_wdata : 32'd0;
  assign oCsrReq   = r_req && r_csr_tgt;
  assign oCsrWe    = oCsrReq && w_write;
  assign oCsrAddr  = oCsrReq ? w_regno[11:0] : 12'd0;
  assign oCsrWdata = oCsrReq ? r_wdata : 32'd0;

endmodule

// File: tb/tb_dbg_abstract_sequencer.sv
module tb_dbg_abstract_sequencer;
  localparam int TO = 255;

  logic        iClk = 1'b0, iRst_n = 1'b0, iClear = 1'b0, iHalted = 1'b1;
  logic        iCmdValid = 1'b0;
  logic [31:0] iCmd = '0, iData0 = '0;
  logic [2:0]  iCmdErrW1c = '0;
  logic        oBusy, oData0We, oRegnoWe;
  logic [2:0]  oCmdErr;
  logic [31:0] oData0;
  logic [15:0] oRegno;
  logic        oRfReq, oRfWe, oCsrReq, oCsrWe;
  logic [4:0]  oRfAddr;
  logic [11:0] oCsrAddr;
  logic [31:0] oRfWdata, oCsrWdata;
  logic        iRfAck = 1'b0, iCsrAck = 1'b0;
  logic [31:0] iRfRdata = '0, iCsrRdata = '0;

  dbg_abstract_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iClear(iClear), .iHalted(iHalted),
    .iCmdValid(iCmdValid), .iCmd(iCmd), .iCmdErrW1c(iCmdErrW1c), .iData0(iData0),
    .oBusy(oBusy), .oCmdErr(oCmdErr), .oData0We(oData0We), .oData0(oData0),
    .oRegnoWe(oRegnoWe), .oRegno(oRegno),
    .oRfReq(oRfReq), .oRfWe(oRfWe), .oRfAddr(oRfAddr), .oRfWdata(oRfWdata),
    .iRfAck(iRfAck), .iRfRdata(iRfRdata),
    .oCsrReq(oCsrReq), .oCsrWe(oCsrWe), .oCsrAddr(oCsrAddr), .oCsrWdata(oCsrWdata),
    .iCsrAck(iCsrAck), .iCsrRdata(iCsrRdata)
  );

  always #5 iClk = ~iClk;

  int n_chk = 0, n_pass = 0;
  logic [31:0] q_data[$];
  logic [15:0] q_regno[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  // bus responder: acks the active port rsp_delay negedges after Req is seen
  logic        rsp_en = 1'b1;
  int          rsp_delay = 1;
  logic [31:0] rsp_rdata = '0;
  logic        req_seen = 1'b0;
  logic        rec_csr, rec_we;
  logic [31:0] rec_addr, rec_wdata;
  initial begin
    int wc = 0;
    forever begin
      @(negedge iClk);
      iRfAck = 1'b0; iCsrAck = 1'b0;
      if (oRfReq || oCsrReq) begin
        req_seen = 1'b1;
        if (rsp_en && wc == rsp_delay) begin
          rec_csr   = oCsrReq;
          rec_we    = oCsrReq ? oCsrWe : oRfWe;
          rec_addr  = oCsrReq ? {20'd0, oCsrAddr} : {27'd0, oRfAddr};
          rec_wdata = oCsrReq ? oCsrWdata : oRfWdata;
          if (oCsrReq) begin iCsrAck = 1'b1; iCsrRdata = rsp_rdata; end
          else         begin iRfAck  = 1'b1; iRfRdata  = rsp_rdata; end
          wc = 100;
        end else wc++;
      end else wc = 0;
    end
  end

  // scoreboard pop side
  always @(negedge iClk) begin
    if (oData0We) begin
      if (q_data.size() == 0) chk("unexpected_data0we", 32'd1, 32'd0);
      else                    chk("data0", oData0, q_data.pop_front());
    end
    if (oRegnoWe) begin
      if (q_regno.size() == 0) chk("unexpected_regnowe", 32'd1, 32'd0);
      else                     chk("regno", {16'd0, oRegno}, {16'd0, q_regno.pop_front()});
    end
  end

  task automatic issue(input logic [31:0] cmd);
    @(negedge iClk); iCmdValid = 1'b1; iCmd = cmd;
    @(negedge iClk); iCmdValid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    while (oBusy && cyc < bound) begin @(negedge iClk); cyc++; end
    if (cyc >= bound) chk("idle_bound", 32'd1, 32'd0);
  endtask

  task automatic w1c();
    @(negedge iClk); iCmdErrW1c = 3'b111;
    @(negedge iClk); iCmdErrW1c = 3'b000;
  endtask

  initial begin
    int cyc;
    #12;
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_cmderr", {29'd0, oCmdErr}, 32'd0);
    chk("rst_req", {30'd0, oRfReq, oCsrReq}, 32'd0);
    @(negedge iClk); iRst_n = 1'b1;
    @(negedge iClk);

    // read x5, ack one cycle after Req
    rsp_rdata = 32'hDEADBEEF; q_data.push_back(32'hDEADBEEF);
    issue(32'h00221005);
    wait_idle(20, cyc);
    chk("rd_x5_busy_cycles", cyc, 32'd4);
    chk("rd_x5_addr", rec_addr, 32'd5);
    chk("rd_x5_cmderr", {29'd0, oCmdErr}, 32'd0);

    // write CSR 0x300
    iData0 = 32'h12345678;
    issue(32'h00230300);
    wait_idle(20, cyc);
    chk("wr_csr_sel", {31'd0, rec_csr}, 32'd1);
    chk("wr_csr_we", {31'd0, rec_we}, 32'd1);
    chk("wr_csr_addr", rec_addr, 32'h300);
    chk("wr_csr_wdata", rec_wdata, 32'h12345678);
    chk("wr_csr_cmderr", {29'd0, oCmdErr}, 32'd0);

    // read x8 with postinc
    rsp_rdata = 32'hA5A50008; q_data.push_back(32'hA5A50008); q_regno.push_back(16'h1009);
    issue(32'h002A1008);
    wait_idle(20, cyc);

    // transfer=0, postinc, regno wraps
    q_regno.push_back(16'h0000);
    issue(32'h0028FFFF);
    wait_idle(20, cyc);
    chk("wrap_cmderr", {29'd0, oCmdErr}, 32'd0);

    // x0 read: no bus cycle, data0 gets zero
    req_seen = 1'b0; q_data.push_back(32'd0);
    issue(32'h00221000);
    wait_idle(20, cyc);
    chk("x0_no_req", {31'd0, req_seen}, 32'd0);

    // not halted
    iHalted = 1'b0; req_seen = 1'b0;
    issue(32'h00221001);
    wait_idle(20, cyc);
    chk("nothalt_cmderr", {29'd0, oCmdErr}, 32'd4);
    chk("nothalt_no_req", {31'd0, req_seen}, 32'd0);
    iHalted = 1'b1;
    issue(32'h00221005);
    chk("err_blocks_cmd", {31'd0, oBusy}, 32'd0);
    w1c();
    chk("w1c_clears", {29'd0, oCmdErr}, 32'd0);

    // second command during WAIT, no ack -> busy error sticks over timeout
    rsp_en = 1'b0;
    issue(32'h00221005);
    @(negedge iClk); @(negedge iClk);
    issue(32'h00230300);
    chk("busy_err", {29'd0, oCmdErr}, 32'd1);
    chk("busy_still_running", {31'd0, oRfReq}, 32'd1);
    wait_idle(400, cyc);
    chk("timeout_cycles", cyc, TO - 1);
    chk("timeout_req_low", {31'd0, oRfReq}, 32'd0);
    chk("first_err_sticks", {29'd0, oCmdErr}, 32'd1);
    w1c();
    rsp_en = 1'b1;

    // aarsize=3
    issue(32'h00321005);
    wait_idle(20, cyc);
    chk("aarsize_err", {29'd0, oCmdErr}, 32'd2);
    w1c();
    // unmapped regno
    issue(32'h0022C000);
    wait_idle(20, cyc);
    chk("regno_err", {29'd0, oCmdErr}, 32'd3);
    w1c();
    // non-zero cmdtype
    issue(32'h01221005);
    wait_idle(20, cyc);
    chk("cmdtype_err", {29'd0, oCmdErr}, 32'd2);
    w1c();

    // clear during WAIT
    rsp_en = 1'b0;
    issue(32'h00221005);
    @(negedge iClk); @(negedge iClk);
    chk("pre_clear_req", {31'd0, oRfReq}, 32'd1);
    iClear = 1'b1;
    @(negedge iClk);
    chk("clear_req", {31'd0, oRfReq}, 32'd0);
    chk("clear_busy", {31'd0, oBusy}, 32'd0);
    iClear = 1'b0;
    rsp_en = 1'b1;
    repeat (3) @(negedge iClk);

    chk("q_data_empty", q_data.size(), 32'd0);
    chk("q_regno_empty", q_regno.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
